// File: rtl/memwb_pkg.sv
// Shared types for the MEM/WB writeback buffer: load-type encoding and the stored entry.
package memwb_pkg;

  // Widest supported datapath and register address; narrower builds use the low bits.
  localparam int MAX_XLEN = 64;
  localparam int MAX_AW   = 16;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LH  = 3'd1,
    LW  = 3'd2,
    LD  = 3'd3,
    LBU = 3'd4,
    LHU = 3'd5,
    LWU = 3'd6
  } load_funct3_e;

  typedef struct packed {
    logic [MAX_XLEN-1:0] wdata;
    logic [MAX_AW-1:0]   waddr;
    logic                regwrite;
    logic                f_regwrite;
  } memwb_entry_t;

endpackage

// File: rtl/memwb_if.sv
// MEM/WB handshake bundle: upstream entry fields in, writeback head entry out.
interface memwb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  localparam int OFFW = $clog2(XLEN / 8);

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_rd_data;
  logic [XLEN-1:0] in_load_data;
  logic [OFFW-1:0] in_byte_off;
  logic [2:0]      in_funct3;
  logic [AW-1:0]   in_waddr;
  logic            in_regwrite;
  logic            in_f_regwrite;
  logic            in_is_load;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_wdata;
  logic [AW-1:0]   out_waddr;
  logic            out_regwrite;
  logic            out_f_regwrite;
  logic [1:0]      out_count;

  modport slave (
    input  in_valid, in_rd_data, in_load_data, in_byte_off, in_funct3,
           in_waddr, in_regwrite, in_f_regwrite, in_is_load, out_ready,
    output in_ready, out_valid, out_wdata, out_waddr, out_regwrite,
           out_f_regwrite, out_count
  );

  modport master (
    output in_valid, in_rd_data, in_load_data, in_byte_off, in_funct3,
           in_waddr, in_regwrite, in_f_regwrite, in_is_load, out_ready,
    input  in_ready, out_valid, out_wdata, out_waddr, out_regwrite,
           out_f_regwrite, out_count
  );

endinterface

// File: rtl/memwb_load_ext.sv
// Load data extraction: selects the addressed byte/half/word lane and sign/zero-extends it.
module memwb_load_ext
  import memwb_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OFFW = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0] load_data_i,
  input  logic [OFFW-1:0] byte_off_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o
);

  logic [OFFW-1:0] off_h;
  logic [OFFW-1:0] off_w;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;
  logic [31:0]     word_v;

  // Misaligned low offset bits are ignored by clearing them before lane select.
  assign off_h  = byte_off_i & ~OFFW'(1);
  assign off_w  = byte_off_i & ~OFFW'(3);
  assign byte_v = load_data_i[{byte_off_i, 3'b000} +: 8];
  assign half_v = load_data_i[{off_h, 3'b000} +: 16];
  assign word_v = load_data_i[{off_w, 3'b000} +: 32];

  always_comb begin
    data_o = load_data_i;
    case (funct3_i)
      LB: begin
        data_o      = {XLEN{byte_v[7]}};
        data_o[7:0] = byte_v;
      end
      LH: begin
        data_o       = {XLEN{half_v[15]}};
        data_o[15:0] = half_v;
      end
      LW: begin
        data_o       = {XLEN{word_v[31]}};
        data_o[31:0] = word_v;
      end
      LBU: begin
        data_o      = '0;
        data_o[7:0] = byte_v;
      end
      LHU: begin
        data_o       = '0;
        data_o[15:0] = half_v;
      end
      LWU: begin
        // On a 32-bit datapath LWU is not a load type and passes the word through.
        if (XLEN == 64) begin
          data_o       = '0;
          data_o[31:0] = word_v;
        end
      end
      default: data_o = load_data_i;
    endcase
  end

endmodule

// File: rtl/memwb_pipe.sv
// MEM/WB writeback buffer: two-entry FIFO holding final write data for the register file.
// Optional build macro MEMWB_X0_DROP_EN discards integer-only writes aimed at register 0.
module memwb_pipe
  import memwb_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   flush,
  memwb_if.slave bus
);

  localparam int OFFW = $clog2(XLEN / 8);

  logic [XLEN-1:0] ld_ext;
  logic [XLEN-1:0] wdata_sel;
  logic            x0_drop;
  logic            push;
  logic            keep;
  logic            pop;
  logic [1:0]      count_q, count_d;
  memwb_entry_t    head_q, head_d;
  memwb_entry_t    skid_q, skid_d;
  memwb_entry_t    new_entry;
  logic            unused_hi;

  memwb_load_ext #(
    .XLEN (XLEN),
    .OFFW (OFFW)
  ) u_load_ext (
    .load_data_i (bus.in_load_data),
    .byte_off_i  (bus.in_byte_off),
    .funct3_i    (bus.in_funct3),
    .data_o      (ld_ext)
  );

  assign wdata_sel = bus.in_is_load ? ld_ext : bus.in_rd_data;

  always_comb begin
    new_entry                  = '0;
    new_entry.wdata[XLEN-1:0]  = wdata_sel;
    new_entry.waddr[AW-1:0]    = bus.in_waddr;
    new_entry.regwrite         = bus.in_regwrite;
    new_entry.f_regwrite       = bus.in_f_regwrite;
  end

`ifdef MEMWB_X0_DROP_EN
  assign x0_drop = (bus.in_waddr == '0) & bus.in_regwrite & ~bus.in_f_regwrite;
`else
  assign x0_drop = 1'b0;
`endif

  assign bus.in_ready  = (count_q != 2'd2);
  assign bus.out_valid = (count_q != 2'd0);
  assign push          = bus.in_valid & bus.in_ready;
  // Entries that write nothing still complete the handshake but never occupy a slot.
  assign keep          = push & (bus.in_regwrite | bus.in_f_regwrite) & ~x0_drop;
  assign pop           = bus.out_valid & bus.out_ready;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case (count_q)
        2'd0: begin
          if (keep) begin
            head_d  = new_entry;
            count_d = 2'd1;
          end
        end
        2'd1: begin
          if (pop && keep) begin
            head_d = new_entry;
          end else if (pop) begin
            count_d = 2'd0;
          end else if (keep) begin
            skid_d  = new_entry;
            count_d = 2'd2;
          end
        end
        default: begin
          if (pop) begin
            head_d  = skid_q;
            count_d = 2'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= 2'd0;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

  // Write enables are qualified by valid so a retired head can never re-trigger a write.
  assign bus.out_wdata      = head_q.wdata[XLEN-1:0];
  assign bus.out_waddr      = head_q.waddr[AW-1:0];
  assign bus.out_regwrite   = head_q.regwrite & bus.out_valid;
  assign bus.out_f_regwrite = head_q.f_regwrite & bus.out_valid;
  assign bus.out_count      = count_q;

  assign unused_hi = ^{head_q.wdata, head_q.waddr};

endmodule

// File: tb/tb_memwb_pipe.sv
// Self-checking bench for memwb_pipe: queue model for the 32-bit build plus literal vectors for 32/64-bit.
module tb_memwb_pipe;
  import memwb_pkg::*;

`ifdef MEMWB_X0_DROP_EN
  localparam bit X0DROP = 1'b1;
`else
  localparam bit X0DROP = 1'b0;
`endif

  logic clk     = 1'b0;
  logic reset   = 1'b0;
  logic flush32 = 1'b0;
  logic flush64 = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  memwb_if #(.XLEN(32), .AW(5)) bus32 ();
  memwb_if #(.XLEN(64), .AW(5)) bus64 ();

  memwb_pipe #(.XLEN(32), .AW(5)) u_dut32 (
    .clk   (clk),
    .reset (reset),
    .flush (flush32),
    .bus   (bus32.slave)
  );

  memwb_pipe #(.XLEN(64), .AW(5)) u_dut64 (
    .clk   (clk),
    .reset (reset),
    .flush (flush64),
    .bus   (bus64.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] wd;
    logic [4:0]  wa;
    logic        rw;
    logic        frw;
  } exp_t;

  exp_t mq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Write data from the load rules, using plain integer arithmetic.
  function automatic logic [31:0] model_wd(input logic isl, input logic [2:0] f3,
                                           input logic [31:0] d, input logic [1:0] off,
                                           input logic [31:0] rd);
    int unsigned b;
    int unsigned h;
    if (!isl) return rd;
    b = (d >> (8 * off)) & 32'hFF;
    h = (d >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b - 256 : b;
      3'd1:    return (h >= 32768) ? h - 65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return d;
    endcase
  endfunction

  function automatic bit model_keep(input logic [4:0] wa, input logic rw, input logic frw);
    return (rw || frw) && !(X0DROP && wa == 5'd0 && rw && !frw);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
    end else if (flush32) begin
      mq.delete();
    end else if (mq.size() == 2) begin
      if (bus32.out_ready) void'(mq.pop_front());
    end else begin
      if (mq.size() == 1 && bus32.out_ready) void'(mq.pop_front());
      if (bus32.in_valid && model_keep(bus32.in_waddr, bus32.in_regwrite, bus32.in_f_regwrite))
        mq.push_back('{model_wd(bus32.in_is_load, bus32.in_funct3, bus32.in_load_data,
                                bus32.in_byte_off, bus32.in_rd_data),
                       bus32.in_waddr, bus32.in_regwrite, bus32.in_f_regwrite});
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      chk("m_count", 64'(bus32.out_count), 64'(mq.size()));
      chk("m_valid", 64'(bus32.out_valid), 64'(mq.size() != 0));
      chk("m_in_ready", 64'(bus32.in_ready), 64'(mq.size() < 2));
      if (mq.size() != 0) begin
        chk("m_wdata", 64'(bus32.out_wdata), 64'(mq[0].wd));
        chk("m_waddr", 64'(bus32.out_waddr), 64'(mq[0].wa));
        chk("m_regwrite", 64'(bus32.out_regwrite), 64'(mq[0].rw));
        chk("m_f_regwrite", 64'(bus32.out_f_regwrite), 64'(mq[0].frw));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive32(input bit v, input logic [2:0] f3, input logic [31:0] ld,
                         input logic [1:0] off, input logic [31:0] rd, input logic [4:0] wa,
                         input bit rw, input bit frw, input bit isl);
    bus32.in_valid      = v;
    bus32.in_funct3     = f3;
    bus32.in_load_data  = ld;
    bus32.in_byte_off   = off;
    bus32.in_rd_data    = rd;
    bus32.in_waddr      = wa;
    bus32.in_regwrite   = rw;
    bus32.in_f_regwrite = frw;
    bus32.in_is_load    = isl;
  endtask

  task automatic idle32();
    drive32(1'b0, 3'd0, 32'h0, 2'd0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drive64(input bit v, input logic [2:0] f3, input logic [63:0] ld,
                         input logic [2:0] off);
    bus64.in_valid      = v;
    bus64.in_funct3     = f3;
    bus64.in_load_data  = ld;
    bus64.in_byte_off   = off;
    bus64.in_rd_data    = 64'h0;
    bus64.in_waddr      = 5'd7;
    bus64.in_regwrite   = v;
    bus64.in_f_regwrite = 1'b0;
    bus64.in_is_load    = 1'b1;
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] ld;
    logic [1:0]  off;
    logic [31:0] exp;
  } vec32_t;

  typedef struct {
    logic [2:0]  f3;
    logic [2:0]  off;
    logic [63:0] exp;
  } vec64_t;

  initial begin
    vec32_t v32[8];
    vec64_t v64[6];
    v32[0] = '{3'd2, 32'hDEAD_BEEF, 2'd1, 32'hDEAD_BEEF};
    v32[1] = '{3'd4, 32'h80FF_00AA, 2'd3, 32'h0000_0080};
    v32[2] = '{3'd0, 32'h1234_567F, 2'd0, 32'h0000_007F};
    v32[3] = '{3'd1, 32'h0000_FFFE, 2'd1, 32'hFFFF_FFFE};
    v32[4] = '{3'd3, 32'hA5A5_0001, 2'd2, 32'hA5A5_0001};
    v32[5] = '{3'd6, 32'h8765_4321, 2'd0, 32'h8765_4321};
    v32[6] = '{3'd7, 32'h0BAD_F00D, 2'd3, 32'h0BAD_F00D};
    v32[7] = '{3'd5, 32'hFFFF_7FFF, 2'd1, 32'h0000_7FFF};
    v64[0] = '{3'd6, 3'd4, 64'h0000_0000_1234_5678};
    v64[1] = '{3'd2, 3'd0, 64'hFFFF_FFFF_8000_0001};
    v64[2] = '{3'd3, 3'd5, 64'h1234_5678_8000_0001};
    v64[3] = '{3'd0, 3'd3, 64'hFFFF_FFFF_FFFF_FF80};
    v64[4] = '{3'd5, 3'd7, 64'h0000_0000_0000_1234};
    v64[5] = '{3'd7, 3'd2, 64'h1234_5678_8000_0001};

    idle32();
    bus32.out_ready = 1'b0;
    drive64(1'b0, 3'd0, 64'h0, 3'd0);
    bus64.out_ready = 1'b1;

    // Reset state
    tick();
    chk("rst_count", 64'(bus32.out_count), 64'd0);
    chk("rst_valid", 64'(bus32.out_valid), 64'd0);
    chk("rst_wdata", 64'(bus32.out_wdata), 64'd0);
    chk("rst_waddr", 64'(bus32.out_waddr), 64'd0);
    chk("rst_regwrite", 64'(bus32.out_regwrite), 64'd0);
    chk("rst_f_regwrite", 64'(bus32.out_f_regwrite), 64'd0);
    tick();
    reset = 1'b1;

    // LB sign extension, one-cycle latency
    bus32.out_ready = 1'b1;
    drive32(1'b1, 3'd0, 32'h0000_80FF, 2'd1, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1);
    tick();
    chk("lb_wdata", 64'(bus32.out_wdata), 64'hFFFF_FF80);
    chk("lb_valid", 64'(bus32.out_valid), 64'd1);

    // LHU then LH back-to-back: push+pop at count 1 advances the head
    drive32(1'b1, 3'd5, 32'h8001_1234, 2'd2, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1);
    tick();
    chk("lhu_wdata", 64'(bus32.out_wdata), 64'h0000_8001);
    drive32(1'b1, 3'd1, 32'h8001_1234, 2'd2, 32'h0, 5'd5, 1'b1, 1'b0, 1'b1);
    tick();
    chk("lh_wdata", 64'(bus32.out_wdata), 64'hFFFF_8001);
    chk("lh_count", 64'(bus32.out_count), 64'd1);
    idle32();
    tick();

    // Backpressure: third entry waits and is accepted in order
    bus32.out_ready = 1'b0;
    drive32(1'b1, 3'd0, 32'h0, 2'd0, 32'h111, 5'd1, 1'b1, 1'b0, 1'b0);
    tick();
    drive32(1'b1, 3'd0, 32'h0, 2'd0, 32'h222, 5'd2, 1'b1, 1'b0, 1'b0);
    tick();
    chk("bp_in_ready", 64'(bus32.in_ready), 64'd0);
    chk("bp_count", 64'(bus32.out_count), 64'd2);
    drive32(1'b1, 3'd0, 32'h0, 2'd0, 32'h333, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    chk("bp_hold_wdata", 64'(bus32.out_wdata), 64'h111);
    bus32.out_ready = 1'b1;
    tick();
    chk("bp_second", 64'(bus32.out_wdata), 64'h222);
    tick();
    idle32();
    chk("bp_third", 64'(bus32.out_wdata), 64'h333);
    chk("bp_third_addr", 64'(bus32.out_waddr), 64'd3);
    tick();

    // Flush beats pop and push in the same cycle
    bus32.out_ready = 1'b0;
    drive32(1'b1, 3'd0, 32'h0, 2'd0, 32'h444, 5'd6, 1'b1, 1'b0, 1'b0);
    tick();
    drive32(1'b1, 3'd0, 32'h0, 2'd0, 32'h555, 5'd7, 1'b1, 1'b0, 1'b0);
    tick();
    flush32 = 1'b1;
    bus32.out_ready = 1'b1;
    drive32(1'b1, 3'd0, 32'h0, 2'd0, 32'h666, 5'd8, 1'b1, 1'b0, 1'b0);
    tick();
    chk("fl_count", 64'(bus32.out_count), 64'd0);
    chk("fl_valid", 64'(bus32.out_valid), 64'd0);
    flush32 = 1'b0;
    idle32();
    tick();
    chk("fl_after", 64'(bus32.out_count), 64'd0);

    // No-write entries are discarded; FP-only writes are kept
    drive32(1'b1, 3'd0, 32'h0, 2'd0, 32'h777, 5'd9, 1'b0, 1'b0, 1'b0);
    tick();
    chk("nowr_count", 64'(bus32.out_count), 64'd0);
    bus32.out_ready = 1'b0;
    drive32(1'b1, 3'd0, 32'h0, 2'd0, 32'h888, 5'd10, 1'b0, 1'b1, 1'b0);
    tick();
    idle32();
    chk("fp_f_regwrite", 64'(bus32.out_f_regwrite), 64'd1);
    chk("fp_regwrite", 64'(bus32.out_regwrite), 64'd0);
    bus32.out_ready = 1'b1;
    tick();

    // Integer write to x0
    bus32.out_ready = 1'b0;
    drive32(1'b1, 3'd0, 32'h0, 2'd0, 32'h999, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    idle32();
    chk("x0_count", 64'(bus32.out_count), X0DROP ? 64'd0 : 64'd1);
    bus32.out_ready = 1'b1;
    tick();

    // Load-type table, streamed back-to-back
    for (int i = 0; i < 8; i++) begin
      drive32(1'b1, v32[i].f3, v32[i].ld, v32[i].off, 32'h0, 5'(i + 11), 1'b1, 1'b0, 1'b1);
      tick();
      chk($sformatf("ld32_%0d", i), 64'(bus32.out_wdata), 64'(v32[i].exp));
    end
    drive32(1'b1, 3'd2, 32'hFFFF_FFFF, 2'd0, 32'hCAFE_F00D, 5'd20, 1'b1, 1'b0, 1'b0);
    tick();
    chk("alu_wdata", 64'(bus32.out_wdata), 64'hCAFE_F00D);
    idle32();
    tick();

    // Reset in the middle of a full buffer
    bus32.out_ready = 1'b0;
    drive32(1'b1, 3'd0, 32'h0, 2'd0, 32'hAAA, 5'd21, 1'b1, 1'b0, 1'b0);
    tick();
    drive32(1'b1, 3'd0, 32'h0, 2'd0, 32'hBBB, 5'd22, 1'b1, 1'b0, 1'b0);
    tick();
    idle32();
    #2 reset = 1'b0;
    #1;
    chk("mr_count", 64'(bus32.out_count), 64'd0);
    chk("mr_valid", 64'(bus32.out_valid), 64'd0);
    chk("mr_wdata", 64'(bus32.out_wdata), 64'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("mr_in_ready", 64'(bus32.in_ready), 64'd1);
    chk("mr_count_after", 64'(bus32.out_count), 64'd0);

    // 64-bit datapath load types
    for (int i = 0; i < 6; i++) begin
      drive64(1'b1, v64[i].f3, 64'h1234_5678_8000_0001, v64[i].off);
      tick();
      chk($sformatf("ld64_%0d", i), bus64.out_wdata, v64[i].exp);
      chk($sformatf("ld64_valid_%0d", i), 64'(bus64.out_valid), 64'd1);
    end
    drive64(1'b0, 3'd0, 64'h0, 3'd0);
    tick();
    chk("ld64_drained", 64'(bus64.out_count), 64'd0);
    chk("ld64_in_ready", 64'(bus64.in_ready), 64'd1);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
